// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write interfaces for instr_encoder.
// The encoder is the slave of instr_req_if and the master of instr_mem_if.

// Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
// The requester holds the fields stable while req_valid is high and req_ready is low.
interface instr_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [3:0]  req_cond;
    logic [3:0]  req_opcode;
    logic        req_imm;
    logic        req_s;
    logic [3:0]  req_rn;
    logic [3:0]  req_rd;
    logic [11:0] req_operand;
    logic [23:0] req_offset;

    modport master (
        output req_valid, req_type, req_cond, req_opcode, req_imm, req_s,
               req_rn, req_rd, req_operand, req_offset,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_type, req_cond, req_opcode, req_imm, req_s,
               req_rn, req_rd, req_operand, req_offset,
        output req_ready
    );
endinterface

// A memory write happens on a rising clk edge where imem_we is high.
// imem_we is only raised in a cycle where imem_ready is high.
interface instr_mem_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  imem_we;
    logic                  imem_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output imem_we, imem_addr, imem_wdata,
        input  imem_ready
    );

    modport slave (
        input  imem_we, imem_addr, imem_wdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction fields into ARM-format words, queues them and writes them to instruction memory.
// Define INSTR_ENCODER_NOP_FILTER_EN to accept NOP requests without writing them.
module instr_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_req_if.slave            req,
    instr_mem_if.master           imem,
    input  logic                  addr_load,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] TYPE_DP  = 2'b00;
    localparam logic [1:0] TYPE_LS  = 2'b01;
    localparam logic [1:0] TYPE_BR  = 2'b10;
    localparam logic [1:0] TYPE_NOP = 2'b11;

    localparam logic [IDX_W:0]        PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    // Encoder
    logic        dp_test;
    logic        dp_move;
    logic        dp_s;
    logic [3:0]  dp_rn;
    logic [3:0]  dp_rd;
    logic [31:0] enc_word;

    always_comb begin
        dp_test  = (req.req_opcode[3:2] == 2'b10);
        dp_move  = (req.req_opcode == 4'b1101) || (req.req_opcode == 4'b1111);
        dp_s     = dp_test ? 1'b1 : req.req_s;
        dp_rd    = dp_test ? 4'h0 : req.req_rd;
        dp_rn    = dp_move ? 4'h0 : req.req_rn;
        enc_word = 32'h0000_0000;
        case (req.req_type)
            TYPE_DP:  enc_word = {req.req_cond, 2'b00, req.req_imm, req.req_opcode,
                                  dp_s, dp_rn, dp_rd, req.req_operand};
            TYPE_LS:  enc_word = {req.req_cond, 2'b01, req.req_imm, req.req_opcode,
                                  req.req_s, req.req_rn, req.req_rd, req.req_operand};
            TYPE_BR:  enc_word = {req.req_cond, 3'b101, req.req_s, req.req_offset};
            TYPE_NOP: enc_word = 32'h0000_0000;
        endcase
    end

    // FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [31:0]    mem_q [DEPTH];
    logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
    logic           full;
    logic           empty;
    logic           accept;
    logic           push;
    logic           pop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign accept = req.req_valid && req.req_ready;

`ifdef INSTR_ENCODER_NOP_FILTER_EN
    assign push = accept && (req.req_type != TYPE_NOP);
`else
    assign push = accept;
`endif

    // addr_load takes priority over a write so the pointer jump is never mixed with an increment
    assign pop = !empty && imem.imem_ready && !addr_load;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= enc_word;
    end

    // Writer: memory pointer and saturating write counter
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    always_comb begin
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        if (addr_load) begin
            waddr_d = addr_base;
            cnt_d   = '0;
        end else if (pop) begin
            waddr_d = waddr_q + ADDR_ONE;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req.req_ready   = !full;
    assign imem.imem_we    = pop;
    assign imem.imem_addr  = waddr_q;
    assign imem.imem_wdata = empty ? 32'h0000_0000 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign busy            = !empty;
    assign wr_count        = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, back-pressure, addr_load and reset corner cases.
`timescale 1ns/1ps
module tb_instr_encoder;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_req_if rif();
  instr_mem_if #(.ADDR_WIDTH(AW)) mif();
  logic          addr_load;
  logic [AW-1:0] addr_base;
  logic          busy;
  logic [AW:0]   wr_count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (rif),
    .imem      (mif),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        imm;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] operand;
    logic [23:0] offset;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [AW:0]   exp_cnt = '0;
  logic exp_we;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every active cycle, compare outputs with the expected queue and pointer model
  always @(negedge clk) begin
    if (reset_n) begin
      exp_we = (exp_q.size() != 0) && mif.imem_ready && !addr_load;
      check("imem_we", mif.imem_we, exp_we);
      check("busy", busy, exp_q.size() != 0);
      check("req_ready", rif.req_ready, exp_q.size() < DEPTH);
      check("imem_addr", mif.imem_addr, exp_addr);
      check("wr_count", wr_count, exp_cnt);
      if (exp_q.size() == 0) check("wdata_empty", mif.imem_wdata, 32'h0);
      else check("wdata_head", mif.imem_wdata, exp_q[0]);
      if (exp_we) begin
        void'(exp_q.pop_front());
        exp_addr = exp_addr + 1'b1;
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
      if (addr_load) begin
        exp_addr = addr_base;
        exp_cnt  = '0;
      end
    end
  end

  // driver: call just after a rising edge; returns just after the accepting edge
  task automatic push(input vec_t v, output int waited, output bit pushed);
    bit rdy;
    bit accepted = 0;
    rif.req_type = v.typ;  rif.req_cond = v.cond;  rif.req_opcode = v.opcode;
    rif.req_imm = v.imm;   rif.req_s = v.s;        rif.req_rn = v.rn;
    rif.req_rd = v.rd;     rif.req_operand = v.operand;  rif.req_offset = v.offset;
    rif.req_valid = 1'b1;
    waited = 0;
    pushed = 0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      rdy = rif.req_ready;
      @(posedge clk);
      if (rdy) begin
        accepted = 1;
`ifdef INSTR_ENCODER_NOP_FILTER_EN
        pushed = (v.typ != 2'b11);
`else
        pushed = 1;
`endif
        if (pushed) exp_q.push_back(v.exp);
      end else begin
        waited++;
      end
    end
    #1 rif.req_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL push_timeout: got not-accepted expected accepted at %0t", $time);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  task automatic reset_checks();
    check("rst_imem_we", mif.imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_imem_addr", mif.imem_addr, 0);
    check("rst_imem_wdata", mif.imem_wdata, 0);
    check("rst_req_ready", rif.req_ready, 1);
    check("rst_wr_count", wr_count, 0);
  endtask

  // asynchronous reset pulse inside a cycle; outputs must clear without a clock edge
  task automatic reset_pulse();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 reset_checks();
    exp_q.delete();
    exp_addr = '0;
    exp_cnt  = '0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit p;
    //               typ    cond  opc      I     S     Rn    Rd    operand  offset      expected
    vecs[0] = '{2'b00, 4'hE, 4'b0100, 1'b1, 1'b0, 4'h2, 4'h1, 12'h005, 24'h000000, 32'hE2821005}; // ADD
    vecs[1] = '{2'b00, 4'hE, 4'b1010, 1'b1, 1'b0, 4'h3, 4'h7, 12'h000, 24'h000000, 32'hE3530000}; // CMP
    vecs[2] = '{2'b01, 4'hE, 4'b1100, 1'b0, 1'b0, 4'h1, 4'h0, 12'h004, 24'h000000, 32'hE5810004}; // STR
    vecs[3] = '{2'b10, 4'hE, 4'hF,    1'b1, 1'b1, 4'h3, 4'h5, 12'hABC, 24'h000010, 32'hEB000010}; // BL
    vecs[4] = '{2'b00, 4'hE, 4'b1101, 1'b1, 1'b1, 4'h5, 4'h2, 12'h0FF, 24'h000000, 32'hE3B020FF}; // MOVS
    vecs[5] = '{2'b01, 4'h0, 4'b1001, 1'b1, 1'b1, 4'hD, 4'hF, 12'hABC, 24'h000000, 32'h073DFABC}; // LDR
    vecs[6] = '{2'b10, 4'h1, 4'h0,    1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 24'hFFFFFE, 32'h1AFFFFFE}; // BNE back
    vecs[7] = '{2'b11, 4'hE, 4'hF,    1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFF, 32'h00000000}; // NOP
    vecs[8] = '{2'b00, 4'hE, 4'b1001, 1'b0, 1'b0, 4'h4, 4'h9, 12'h123, 24'h000000, 32'hE1340123}; // TEQ
    vecs[9] = '{2'b00, 4'hE, 4'b1111, 1'b0, 1'b0, 4'h6, 4'h3, 12'h00A, 24'h000000, 32'hE1E0300A}; // MVN

    rif.req_valid = 1'b0; rif.req_type = 2'b00; rif.req_cond = 4'h0; rif.req_opcode = 4'h0;
    rif.req_imm = 1'b0; rif.req_s = 1'b0; rif.req_rn = 4'h0; rif.req_rd = 4'h0;
    rif.req_operand = 12'h0; rif.req_offset = 24'h0;
    mif.imem_ready = 1'b0;
    addr_load = 1'b0;
    addr_base = '0;

    // power-on reset
    repeat (2) @(posedge clk);
    #1 reset_checks();
    @(posedge clk);
    #2 reset_n = 1'b1;

    // encoding table, one word at a time with an open memory
    mif.imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i], w, p);
      @(negedge clk);
      if (p) begin
        check("lat_we", mif.imem_we, 1);
        check("lat_wdata", mif.imem_wdata, vecs[i].exp);
      end else begin
        check("nop_filtered_we", mif.imem_we, 0);
      end
      @(posedge clk); #1;
    end
    drain();

    // sustained throughput: no wait cycles with memory always ready
    for (int i = 0; i < 6; i++) begin
      push(vecs[i], w, p);
      check("stream_wait", w, 0);
    end
    drain();

    // back-pressure: fill the FIFO, then release memory with a fifth request pending
    reset_pulse();
    mif.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[i], w, p);
    @(negedge clk);
    check("full_ready", rif.req_ready, 0);
    check("full_busy", busy, 1);
    check("full_we", mif.imem_we, 0);
    @(posedge clk); #1;
    mif.imem_ready = 1'b1;
    push(vecs[4], w, p);
    check("fifth_wait", w, 1);
    drain();
    @(negedge clk);
    check("bp_wr_count", wr_count, 5);
    check("bp_addr", mif.imem_addr, 5);
    @(posedge clk); #1;

    // addr_load to the top of memory, writes wrap to zero
    addr_load = 1'b1; addr_base = 8'hFF;
    @(posedge clk); #1;
    addr_load = 1'b0;
    push(vecs[0], w, p);
    push(vecs[1], w, p);
    drain();
    @(negedge clk);
    check("wrap_wr_count", wr_count, 2);
    check("wrap_addr", mif.imem_addr, 8'h01);
    @(posedge clk); #1;

    // addr_load while a word is queued suppresses the write for that cycle
    mif.imem_ready = 1'b0;
    push(vecs[2], w, p);
    addr_load = 1'b1; addr_base = 8'h40; mif.imem_ready = 1'b1;
    @(negedge clk);
    check("load_we", mif.imem_we, 0);
    check("load_busy", busy, 1);
    @(posedge clk); #1;
    addr_load = 1'b0;
    @(negedge clk);
    check("after_load_we", mif.imem_we, 1);
    check("after_load_addr", mif.imem_addr, 8'h40);
    check("after_load_wdata", mif.imem_wdata, 32'hE5810004);
    @(posedge clk); #1;
    drain();

    // reset while two words are held back, then a NOP request
    mif.imem_ready = 1'b0;
    push(vecs[3], w, p);
    push(vecs[5], w, p);
    reset_pulse();
    mif.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(vecs[7], w, p);
    @(negedge clk);
    if (p) begin
      check("nop_we", mif.imem_we, 1);
      check("nop_wdata", mif.imem_wdata, 32'h0);
      check("nop_addr", mif.imem_addr, 0);
    end else begin
      check("nop_we", mif.imem_we, 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("nop_final_addr", mif.imem_addr, p ? 1 : 0);
    check("nop_final_count", wr_count, p ? 1 : 0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader: packs instruction fields into 32-bit ARM-format words, buffers them in a small FIFO and writes them sequentially into instruction memory. Sits between the test/boot loader and instruction memory, producing exactly the encodings the control unit decodes (data processing, load/store, branch, all-zero NOP). Lets benches and boot code build programs from fields instead of hand-assembled hex.

## Interface
- DEPTH, 4: FIFO depth in words; power of 2, ≥2
- ADDR_WIDTH, 8: instruction memory word-address width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_type  in  2  00 data processing, 01 load/store, 10 branch, 11 NOP
- req_cond  in  4  condition field [31:28]
- req_opcode  in  4  DP opcode; for load/store {P,U,B,W}
- req_imm  in  1  I bit [25] (DP and load/store)
- req_s  in  1  S bit (DP), L bit (load/store [20], branch [24])
- req_rn  in  4  Rn [19:16]
- req_rd  in  4  Rd [15:12]
- req_operand  in  12  operand2 / offset12 [11:0]
- req_offset  in  24  branch offset [23:0]
- addr_load  in  1  load write pointer from addr_base
- addr_base  in  ADDR_WIDTH  new write pointer
- imem_ready  in  1  memory accepts a write this cycle
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_WIDTH  write word address
- imem_wdata  out  32  write data
- busy  out  1  FIFO non-empty
- wr_count  out  ADDR_WIDTH+1  words written since reset/addr_load, saturating

## Operation
- Encoding (combinational, at push):
  - DP: {cond, 00, I, opcode, S, Rn, Rd, operand}. TST/TEQ/CMP/CMN (10xx): S forced 1, Rd forced 0. MOV/MVN (1101/1111): Rn forced 0.
  - Load/store: {cond, 01, I, opcode, L, Rn, Rd, operand}.
  - Branch: {cond, 101, L, offset}.
  - NOP: 32'h0000_0000 regardless of other fields.
- FIFO: push on req_valid && req_ready; req_ready = !full. No push when full even if popping same cycle.
- Writer: imem_we = !empty && imem_ready && !addr_load; imem_addr = write pointer; imem_wdata = FIFO head, 0 when empty. On imem_we: pop, pointer +1 mod 2^ADDR_WIDTH, wr_count +1 (saturate at all-ones).
- addr_load: pointer ← addr_base, wr_count ← 0; write suppressed that cycle (FIFO unchanged). Pushes unaffected.
- Simultaneous push/pop when not full: both occur, occupancy unchanged.
- Write order strictly equals acceptance order.

## Timing
- Reset (asynchronous, immediate): FIFO empty, pointer 0, wr_count 0 → imem_we 0, imem_addr 0, imem_wdata 0, busy 0, req_ready 1. Reset mid-drain discards queued words.
- Latency: word accepted at edge N appears at FIFO head in cycle N+1; written in cycle N+1 if FIFO was empty and imem_ready=1.
- Throughput: one accept and one write per cycle sustained.
- req_ready rises the cycle after the pop that leaves the FIFO non-full.
- imem_ready low holds head, address, data stable.

## Configuration
- INSTR_ENCODER_NOP_FILTER_EN defined: NOP requests are accepted (req_ready obeys full) but not pushed; no write, no pointer or wr_count change.
- Undefined: NOP requests push and write 32'h0000_0000 like any other word.

## Test plan
- DP ADD cond E, I=1, opcode 0100, S=0, Rn 2, Rd 1, operand 0x005, imem_ready=1 → next cycle imem_we=1, addr 0x00, wdata 0xE2821005.
- DP CMP cond E, I=1, opcode 1010, S=0, Rn 3, Rd 7, operand 0 → S/Rd forced, wdata 0xE3530000.
- STR cond E, I=0, opcode 1100, L=0, Rn 1, Rd 0, operand 0x004 → 0xE5810004; then branch cond E, L=1, offset 0x000010 → 0xEB000010 at addr 0x01.
- imem_ready=0, push 5 back-to-back → req_ready low after 4th, busy=1, imem_we=0; raise imem_ready → 4 words at addresses 0..3 in order, 5th accepted the cycle after first pop, written at 4.
- addr_load with addr_base 0xFF, then 2 words → writes at 0xFF then 0x00, wr_count=2; addr_load in a cycle with FIFO non-empty → no write that cycle.
- Two words queued, imem_ready=0, pulse reset_n low mid-cycle → imem_we/busy/addr 0 immediately, req_ready 1; NOP request → wdata 0 written (macro off) / no write, pointer unchanged (macro on).
